reg_snapshot_reader: RTL and testbench
======================================

Name: reg_snapshot_reader

Overview:
- Read-side companion to the CPU's clock-enabled 32-bit state registers (PC, IR, MDR, A, B, ...).
- On request, it atomically captures NREG register values and streams them out as bytes over a valid/ready handshake.
- The stream feeds the debug/UART or display path, so architectural state can be read without stalling the datapath.

Parameters:
NREG, 4, number of 32-bit registers captured per snapshot (legal 1..16)
IW, $clog2(NREG) (min 1), register index width (derived, not overridden)

Ports:
clk      input   1         system clock, all state on rising edge
rst      input   1         asynchronous, active-low reset
start    input   1         snapshot request, sampled only in IDLE
regs_in  input   NREG*32   flat register bus; reg i at bits [32*i+31:32*i]
busy     output  1         high from capture edge until the last byte is accepted
tx_data  output  8         current byte
tx_valid output  1         tx_data is valid
tx_ready input   1         sink accepts tx_data when tx_valid && tx_ready at clk edge
done     output  1         one-cycle pulse after the final byte is accepted

Behaviour:
- Reset (rst low, async):
  - State = IDLE.
  - busy=0, tx_valid=0, tx_data=8'h00, done=0.
  - Snapshot buffer and counters are cleared to 0.
- States: IDLE, SEND.
- IDLE:
  - start=1 at edge E0 copies all of regs_in into the snapshot buffer at E0.
  - Clears reg_idx=0 and byte_idx=0, then moves to SEND.
  - From the cycle after E0: busy=1, tx_valid=1, tx_data = byte 0. Latency is 1 cycle.
- Byte order:
  - Register 0 first, ascending index.
  - Within a register, MSB byte first (bits 31:24, 23:16, 15:8, 7:0), big-endian as in MIPS.
- SEND handshake:
  - tx_data and tx_valid are registered and held stable while tx_valid && !tx_ready.
  - On an edge with tx_valid && tx_ready, advance byte_idx; on byte_idx wrap 3->0, advance reg_idx.
  - The next byte is presented in the following cycle, so no bubble is allowed: one byte per cycle at tx_ready=1.
  - The sink must not see tx_valid deasserted mid-transfer.
- Completion:
  - The handshake of the last byte (reg_idx=NREG-1, byte_idx=3) moves the block to IDLE.
  - Next cycle: tx_valid=0, busy=0, done=1 for exactly one cycle.
  - Total transfer is 4*NREG handshakes.
- start while busy is ignored, with no queuing.
- start in the done cycle is legal (state is IDLE): it captures a new snapshot at that edge and emits its first byte one cycle later.
- regs_in changes after capture do not affect the transfer. The snapshot is atomic at the capture edge.
- Reset mid-transfer:
  - The transfer is aborted immediately and tx_valid drops asynchronously.
  - No done pulse is produced; the next start begins from register 0, byte 0.
- tx_ready while tx_valid=0 is ignored.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_SEND) and BYTES_PER_REG=4, reused by other debug readers.
- One natural sub-module: snapshot_buf, an NREG x 32 capture store with a load strobe and an (reg_idx, byte_idx) -> byte mux.
- FSM, counters, and handshake logic live in the top module.

Test Plan:
1. NREG=2, regs_in={32'hCAFEBABE, 32'h12345678} (reg1, reg0), tx_ready=1, start pulse -> bytes 12,34,56,78,CA,FE,BA,BE on 8 consecutive cycles starting 1 cycle after start; done pulses once on the cycle after the 8th handshake; busy high for exactly 8 cycles.
2. Backpressure: hold tx_ready=0 for 5 cycles on byte 2 -> tx_data stays 8'h56 with tx_valid=1 throughout; no byte is skipped or duplicated after tx_ready returns to 1.
3. Capture atomicity: change reg0 to 32'hFFFFFFFF one cycle after start -> the stream still emits 12,34,56,78.
4. start pulsed while busy on byte 3 -> the stream is unaffected, exactly one done pulse, and no second transfer begins.
5. Reset low during byte 5, then released and start again -> tx_valid, busy, and done are 0 during reset; the new transfer begins with byte 8'h12; no done pulse from the aborted transfer.
6. start held high continuously with tx_ready=1 -> transfers run back to back. The second capture occurs on the done-cycle edge, and its first byte appears 1 cycle after done.

Source files
------------

// File: rtl/reg_snapshot_reader_pkg.sv
// Shared definitions for debug register readers: FSM states, byte geometry
// and the big-endian byte picker used to serialise 32-bit words.
package reg_snapshot_reader_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int unsigned BYTES_PER_REG = 4;
  localparam int unsigned BYTE_IW       = 2;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] reg_byte(input logic [31:0] word,
                                          input logic [BYTE_IW-1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_snapshot_reader_snapshot_buf.sv
// NREG x 32 capture store, loaded in one edge, read one byte at a time
// through a (reg_idx, byte_idx) mux.
module snapshot_buf
  import reg_snapshot_reader_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned IW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [NREG*32-1:0]   regs_in,
  input  logic [IW-1:0]        reg_idx,
  input  logic [BYTE_IW-1:0]   byte_idx,
  output logic [7:0]           byte_out
);

  logic [31:0] mem_q [NREG];
  logic [31:0] mem_d [NREG];

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      mem_d[i] = load ? regs_in[32*i +: 32] : mem_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign byte_out = reg_byte(mem_q[reg_idx], byte_idx);

endmodule

// File: rtl/reg_snapshot_reader.sv
// Captures NREG 32-bit registers atomically on start and streams them as
// big-endian bytes over a valid/ready handshake, pulsing done at the end.
module reg_snapshot_reader
  import reg_snapshot_reader_pkg::*;
#(
  parameter int unsigned NREG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NREG*32-1:0]   regs_in,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 done
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [IW-1:0]      LAST_REG  = IW'(NREG - 1);
  localparam logic [BYTE_IW-1:0] LAST_BYTE = BYTE_IW'(BYTES_PER_REG - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        reg_idx_q, reg_idx_d, nxt_reg_idx;
  logic [BYTE_IW-1:0]   byte_idx_q, byte_idx_d, nxt_byte_idx;
  logic [7:0]           tx_data_q, tx_data_d, buf_byte;
  logic                 done_q, done_d;
  logic                 load;

  // Buffer is addressed with the post-handshake position so the following
  // byte is registered into tx_data on the same edge, leaving no bubble.
  assign nxt_byte_idx = byte_idx_q + 1'b1;
  assign nxt_reg_idx  = (byte_idx_q == LAST_BYTE) ? reg_idx_q + 1'b1 : reg_idx_q;

  snapshot_buf #(
    .NREG (NREG),
    .IW   (IW)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .regs_in  (regs_in),
    .reg_idx  (nxt_reg_idx),
    .byte_idx (nxt_byte_idx),
    .byte_out (buf_byte)
  );

  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // First byte comes straight from regs_in; the buffer fills on the same edge.
          load       = 1'b1;
          state_d    = ST_SEND;
          reg_idx_d  = '0;
          byte_idx_d = '0;
          tx_data_d  = reg_byte(regs_in[31:0], '0);
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (reg_idx_q == LAST_REG && byte_idx_q == LAST_BYTE) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            reg_idx_d  = '0;
            byte_idx_d = '0;
            tx_data_d  = '0;
          end else begin
            reg_idx_d  = nxt_reg_idx;
            byte_idx_d = nxt_byte_idx;
            tx_data_d  = buf_byte;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == ST_SEND);
  assign tx_valid = (state_q == ST_SEND);
  assign tx_data  = tx_data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reg_snapshot_reader.sv
// Self-checking bench for reg_snapshot_reader (NREG=2) against a byte-queue
// reference model built from the register values at capture time.
module tb_reg_snapshot_reader;

  localparam int NREG = 2;
  localparam int NB   = 4 * NREG;

  typedef logic [7:0] bq_t[$];

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [NREG*32-1:0]  regs_in;
  logic                busy;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  reg_snapshot_reader #(.NREG(NREG)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .regs_in  (regs_in),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: register 0 first, each word most significant byte first.
  function automatic bq_t model(input logic [31:0] r0, input logic [31:0] r1);
    logic [31:0] snap [NREG];
    bq_t q;
    snap[0] = r0;
    snap[1] = r1;
    q = {};
    for (int i = 0; i < NB; i++) begin
      q.push_back(8'((snap[i / 4] >> (8 * (3 - (i % 4)))) & 32'hFF));
    end
    return q;
  endfunction

  function automatic logic [8*NB-1:0] pack(input bq_t q);
    logic [8*NB-1:0] v;
    v = '0;
    for (int i = 0; i < q.size() && i < NB; i++) v[8*(NB-1-i) +: 8] = q[i];
    return v;
  endfunction

  // Accepts bytes until done plus 'extra' cycles; optional stall, start poke, random ready.
  task automatic drain(input int stall_at, input int stall_len, input int start_at,
                       input bit rnd, input int extra,
                       output bq_t got, output int done_cnt, output int busy_cyc,
                       output int gap, output int stall_bad, output bit timeout);
    int stalled, after;
    bit fin, pend;
    logic [7:0] pend_data;
    got = {}; done_cnt = 0; busy_cyc = 0; gap = 0; stall_bad = 0; timeout = 1'b1;
    stalled = 0; after = 0; fin = 1'b0; pend = 1'b0; pend_data = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        done_cnt++;
        fin = 1'b1;
        timeout = 1'b0;
      end
      if (!fin && tx_valid !== 1'b1) gap++;
      if (pend && (tx_valid !== 1'b1 || tx_data !== pend_data)) stall_bad++;
      start = (got.size() == start_at && tx_valid === 1'b1);
      if (tx_valid === 1'b1) begin
        if (got.size() == stall_at && stalled < stall_len) begin
          tx_ready = 1'b0;
          stalled++;
        end else begin
          tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        pend = !tx_ready;
        pend_data = tx_data;
        if (tx_ready) got.push_back(tx_data);
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
        pend = 1'b0;
      end
      if (fin) begin
        if (after == extra) break;
        after++;
      end
      step();
    end
    start = 1'b0;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; tx_ready = 1'b0; regs_in = '0;
    #3;
    total_cnt++;
    if ({busy, tx_valid, done, tx_data} !== 11'h0) begin
      $display("FAIL reset_async: {busy,valid,done,data}=%h expected 000", {busy, tx_valid, done, tx_data});
    end else pass_cnt++;
    step(); step();
    total_cnt++;
    if ({busy, tx_valid, done, tx_data} !== 11'h0) begin
      $display("FAIL reset_hold: {busy,valid,done,data}=%h expected 000", {busy, tx_valid, done, tx_data});
    end else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++;
    if ({busy, tx_valid, done} !== 3'b000) begin
      $display("FAIL reset_release_idle: {busy,valid,done}=%b expected 000", {busy, tx_valid, done});
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    bq_t got, exp;
    int dc, bc, gp, sb;
    bit to;
    regs_in = {32'hCAFEBABE, 32'h12345678};
    exp = model(32'h12345678, 32'hCAFEBABE);
    start = 1'b1;
    step();
    start = 1'b0;
    drain(-1, 0, -1, 1'b0, 3, got, dc, bc, gp, sb, to);
    total_cnt++;
    if (to || got.size() != NB) $display("FAIL basic_count: bytes=%0d timeout=%0b expected %0d bytes", got.size(), to, NB);
    else pass_cnt++;
    total_cnt++;
    if (pack(got) !== pack(exp)) $display("FAIL basic_stream: got %h expected %h", pack(got), pack(exp));
    else pass_cnt++;
    total_cnt++;
    if (dc != 1) $display("FAIL basic_done: done pulses %0d expected 1", dc);
    else pass_cnt++;
    total_cnt++;
    if (bc != NB) $display("FAIL basic_busy: busy cycles %0d expected %0d", bc, NB);
    else pass_cnt++;
    total_cnt++;
    if (gp != 0) $display("FAIL basic_latency_gap: valid-low cycles %0d expected 0", gp);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bq_t got, exp;
    int dc, bc, gp, sb;
    bit to;
    regs_in = {32'hCAFEBABE, 32'h12345678};
    exp = model(32'h12345678, 32'hCAFEBABE);
    start = 1'b1;
    step();
    start = 1'b0;
    drain(2, 5, -1, 1'b0, 2, got, dc, bc, gp, sb, to);
    total_cnt++;
    if (to || pack(got) !== pack(exp) || got.size() != NB)
      $display("FAIL bp_stream: got %h (%0d bytes) expected %h", pack(got), got.size(), pack(exp));
    else pass_cnt++;
    total_cnt++;
    if (sb != 0 || gp != 0) $display("FAIL bp_hold: unstable stall cycles %0d valid gaps %0d expected 0/0", sb, gp);
    else pass_cnt++;
    total_cnt++;
    if (bc != NB + 5 || dc != 1) $display("FAIL bp_busy_done: busy %0d done %0d expected %0d/1", bc, dc, NB + 5);
    else pass_cnt++;
  endtask

  task automatic test_atomic();
    bq_t got, exp;
    int dc, bc, gp, sb;
    bit to;
    regs_in = {32'hCAFEBABE, 32'h12345678};
    exp = model(32'h12345678, 32'hCAFEBABE);
    start = 1'b1;
    step();
    start = 1'b0;
    regs_in[31:0] = 32'hFFFFFFFF;
    drain(-1, 0, -1, 1'b0, 1, got, dc, bc, gp, sb, to);
    total_cnt++;
    if (to || pack(got) !== pack(exp)) $display("FAIL atomic_stream: got %h expected %h", pack(got), pack(exp));
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    bq_t got, exp;
    int dc, bc, gp, sb;
    bit to;
    regs_in = {32'hCAFEBABE, 32'h12345678};
    exp = model(32'h12345678, 32'hCAFEBABE);
    start = 1'b1;
    step();
    start = 1'b0;
    regs_in = {32'h0BADF00D, 32'hDEADBEEF};
    drain(-1, 0, 3, 1'b0, 5, got, dc, bc, gp, sb, to);
    total_cnt++;
    if (to || pack(got) !== pack(exp) || got.size() != NB)
      $display("FAIL busy_start_stream: got %h (%0d bytes) expected %h", pack(got), got.size(), pack(exp));
    else pass_cnt++;
    total_cnt++;
    if (dc != 1 || bc != NB) $display("FAIL busy_start_single: done %0d busy %0d expected 1/%0d", dc, bc, NB);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bq_t got, exp;
    int dc, bc, gp, sb;
    bit to;
    int early_done;
    regs_in = {32'hCAFEBABE, 32'h12345678};
    exp = model(32'h12345678, 32'hCAFEBABE);
    early_done = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    tx_ready = 1'b1;
    repeat (5) step();
    total_cnt++;
    if (tx_valid !== 1'b1 || tx_data !== exp[5]) $display("FAIL mid_byte5: valid %b data %h expected 1/%h", tx_valid, tx_data, exp[5]);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({busy, tx_valid, done} !== 3'b000) $display("FAIL mid_async_abort: {busy,valid,done}=%b expected 000", {busy, tx_valid, done});
    else pass_cnt++;
    step();
    if (done !== 1'b0) early_done++;
    step();
    if (done !== 1'b0) early_done++;
    rst = 1'b1;
    tx_ready = 1'b0;
    step();
    if (done !== 1'b0) early_done++;
    step();
    if (done !== 1'b0) early_done++;
    total_cnt++;
    if (early_done != 0 || busy !== 1'b0) $display("FAIL mid_no_done: done cycles %0d busy %b expected 0/0", early_done, busy);
    else pass_cnt++;
    start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if (tx_data !== 8'h12 || tx_valid !== 1'b1) $display("FAIL mid_restart_first: valid %b data %h expected 1/12", tx_valid, tx_data);
    else pass_cnt++;
    drain(-1, 0, -1, 1'b0, 2, got, dc, bc, gp, sb, to);
    total_cnt++;
    if (to || pack(got) !== pack(exp) || dc != 1) $display("FAIL mid_restart_stream: got %h done %0d expected %h/1", pack(got), dc, pack(exp));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bq_t got1, got2, exp;
    int done_cyc[$];
    logic v9;
    logic [7:0] d9;
    regs_in = {32'hCAFEBABE, 32'h12345678};
    exp = model(32'h12345678, 32'hCAFEBABE);
    got1 = {}; got2 = {}; done_cyc = {}; v9 = 1'b0; d9 = '0;
    tx_ready = 1'b1;
    start = 1'b1;
    step();
    for (int cyc = 0; cyc <= 17; cyc++) begin
      if (done === 1'b1) done_cyc.push_back(cyc);
      if (cyc == 9) begin v9 = tx_valid; d9 = tx_data; end
      if (tx_valid === 1'b1) begin
        if (cyc < 9) got1.push_back(tx_data);
        else got2.push_back(tx_data);
      end
      if (cyc == 17) start = 1'b0;
      step();
    end
    tx_ready = 1'b0;
    total_cnt++;
    if (done_cyc.size() != 2 || done_cyc[0] != 8 || done_cyc[1] != 17)
      $display("FAIL b2b_done_timing: %0d pulses first at %0d expected 2 at 8,17", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
    else pass_cnt++;
    total_cnt++;
    if (v9 !== 1'b1 || d9 !== 8'h12) $display("FAIL b2b_restart_latency: valid %b data %h expected 1/12", v9, d9);
    else pass_cnt++;
    total_cnt++;
    if (pack(got1) !== pack(exp) || pack(got2) !== pack(exp))
      $display("FAIL b2b_streams: first %h second %h expected %h", pack(got1), pack(got2), pack(exp));
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_stop: busy %b done %b expected 0/0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bq_t got, exp;
    int dc, bc, gp, sb;
    bit to;
    logic [31:0] r0, r1;
    for (int it = 0; it < 6; it++) begin
      r0 = $urandom;
      r1 = $urandom;
      regs_in = {r1, r0};
      exp = model(r0, r1);
      start = 1'b1;
      step();
      start = 1'b0;
      regs_in = {$urandom, $urandom};
      drain(-1, 0, -1, 1'b1, 1, got, dc, bc, gp, sb, to);
      total_cnt++;
      if (to || pack(got) !== pack(exp) || got.size() != NB)
        $display("FAIL rand_stream[%0d]: got %h (%0d bytes) expected %h", it, pack(got), got.size(), pack(exp));
      else pass_cnt++;
      total_cnt++;
      if (sb != 0 || gp != 0 || dc != 1)
        $display("FAIL rand_handshake[%0d]: unstable %0d gaps %0d done %0d expected 0/0/1", it, sb, gp, dc);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_atomic();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
